grid_io_multi_cfg: RTL and testbench



---
 rtl/grid_io_multi_cfg_pkg.sv | 23 ++
 rtl/grid_io_multi_cfg_if.sv | 32 +++
 rtl/grid_io_multi_cfg_pad_cell.sv | 76 +++++++
 rtl/grid_io_multi_cfg.sv | 92 +++++++++
 tb/tb_grid_io_multi_cfg.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/grid_io_multi_cfg_pkg.sv
// Shared constants for the multi-pad IO grid tile: per-pad config field layout and mode codes.
// The optional readback path in the top is enabled by defining GRID_IO_READBACK_EN.
package grid_io_pkg;

  localparam int CFG_W = 3;

  localparam int REG_EN_BIT = 2;
  localparam int MODE_LSB   = 0;

  localparam logic [1:0] MODE_DIS   = 2'b00;
  localparam logic [1:0] MODE_IN    = 2'b01;
  localparam logic [1:0] MODE_OUT   = 2'b10;
  localparam logic [1:0] MODE_BIDIR = 2'b11;

  function automatic logic [1:0] cfg_mode(input logic [CFG_W-1:0] cfg);
    return cfg[MODE_LSB +: 2];
  endfunction

  function automatic logic cfg_reg_en(input logic [CFG_W-1:0] cfg);
    return cfg[REG_EN_BIT];
  endfunction

endpackage

// File: rtl/grid_io_multi_cfg_if.sv
// Pad-ring and fabric-side signals of the IO grid tile, one bit per pad channel.
// The tile takes the slave view; whatever drives fabric data and the pad receivers takes the master view.
interface grid_io_multi_cfg_if #(
  parameter int NUM_PADS = 4
);

  logic [NUM_PADS-1:0] io_outpad;
  logic [NUM_PADS-1:0] io_oe_fabric;
  logic [NUM_PADS-1:0] io_inpad;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD_in;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD_out;
  logic [NUM_PADS-1:0] gfpga_pad_GPIO_PAD_oe;

  modport master (
    output io_outpad,
    output io_oe_fabric,
    output gfpga_pad_GPIO_PAD_in,
    input  io_inpad,
    input  gfpga_pad_GPIO_PAD_out,
    input  gfpga_pad_GPIO_PAD_oe
  );

  modport slave (
    input  io_outpad,
    input  io_oe_fabric,
    input  gfpga_pad_GPIO_PAD_in,
    output io_inpad,
    output gfpga_pad_GPIO_PAD_out,
    output gfpga_pad_GPIO_PAD_oe
  );

endinterface

// File: rtl/grid_io_multi_cfg_pad_cell.sv
// One GPIO channel: optional one-cycle register on out/oe/inpad, then mode gating.
// The flops load every cycle so a mode change never exposes stale or undefined register state.
module grid_io_pad_cell
  import grid_io_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CFG_W-1:0] i_cfg,
  input  logic             i_outpad,
  input  logic             i_oe_fabric,
  input  logic             i_pad_in,
  output logic             o_inpad,
  output logic             o_pad_out,
  output logic             o_pad_oe
);

  logic       r_out;
  logic       r_oe;
  logic       r_in;
  logic       w_reg_en;
  logic [1:0] w_mode;
  logic       w_out_src;
  logic       w_oe_src;
  logic       w_in_src;

  assign w_reg_en = cfg_reg_en(i_cfg);
  assign w_mode   = cfg_mode(i_cfg);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= 1'b0;
      r_oe  <= 1'b0;
      r_in  <= 1'b0;
    end else begin
      r_out <= i_outpad;
      r_oe  <= i_oe_fabric;
      r_in  <= i_pad_in;
    end
  end

  assign w_out_src = w_reg_en ? r_out : i_outpad;
  assign w_oe_src  = w_reg_en ? r_oe  : i_oe_fabric;
  assign w_in_src  = w_reg_en ? r_in  : i_pad_in;

  // Gating sits after the register so oe switches at the commit edge itself.
  always_comb begin
    o_inpad   = 1'b0;
    o_pad_out = 1'b0;
    o_pad_oe  = 1'b0;
    case (w_mode)
      MODE_DIS: begin
        o_inpad   = 1'b0;
        o_pad_out = 1'b0;
        o_pad_oe  = 1'b0;
      end
      MODE_IN: begin
        o_inpad   = w_in_src;
      end
      MODE_OUT: begin
        o_pad_out = w_out_src;
        o_pad_oe  = 1'b1;
      end
      MODE_BIDIR: begin
        o_inpad   = w_in_src;
        o_pad_out = w_out_src;
        o_pad_oe  = w_oe_src;
      end
      default: begin
        o_inpad   = 1'b0;
        o_pad_out = 1'b0;
        o_pad_oe  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/grid_io_multi_cfg.sv
// NUM_PADS-channel IO grid tile sharing one bit-counted config chain with a validated commit.
// Define GRID_IO_READBACK_EN to add ccff_readback, which reloads the chain from the active config.
module grid_io_multi_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_PADS = 4
) (
  input  logic prog_clk,
  input  logic pReset,
  input  logic ccff_head,
  input  logic ccff_en,
  input  logic ccff_commit,
`ifdef GRID_IO_READBACK_EN
  input  logic ccff_readback,
`endif
  output logic ccff_tail,
  output logic cfg_valid,
  output logic cfg_err,
  grid_io_multi_cfg_if.slave pads
);

  localparam int CHAIN_LEN = NUM_PADS * CFG_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] r_shreg;
  logic [CHAIN_LEN-1:0] r_active;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_valid;
  logic                 r_err;

  logic [NUM_PADS-1:0]  w_inpad;
  logic [NUM_PADS-1:0]  w_pad_out;
  logic [NUM_PADS-1:0]  w_pad_oe;

  // Commit wins over readback and shifting; a wrong count leaves the live config untouched.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_shreg  <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (ccff_commit) begin
      if (r_cnt == CNT_FULL) begin
        r_active <= r_shreg;
        r_valid  <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_err    <= 1'b1;
      end
      r_cnt <= '0;
    end
`ifdef GRID_IO_READBACK_EN
    else if (ccff_readback) begin
      r_shreg <= r_active;
      r_cnt   <= CNT_FULL;
    end
`endif
    else if (ccff_en) begin
      r_shreg <= {r_shreg[CHAIN_LEN-2:0], ccff_head};
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ccff_tail = r_shreg[CHAIN_LEN-1];
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    grid_io_pad_cell u_cell (
      .i_clk       (prog_clk),
      .i_rst       (pReset),
      .i_cfg       (r_active[CFG_W*p +: CFG_W]),
      .i_outpad    (pads.io_outpad[p]),
      .i_oe_fabric (pads.io_oe_fabric[p]),
      .i_pad_in    (pads.gfpga_pad_GPIO_PAD_in[p]),
      .o_inpad     (w_inpad[p]),
      .o_pad_out   (w_pad_out[p]),
      .o_pad_oe    (w_pad_oe[p])
    );
  end

  assign pads.io_inpad              = w_inpad;
  assign pads.gfpga_pad_GPIO_PAD_out = w_pad_out;
  assign pads.gfpga_pad_GPIO_PAD_oe  = w_pad_oe;

endmodule

// File: tb/tb_grid_io_multi_cfg.sv
// Directed bench for grid_io_multi_cfg with NUM_PADS=2 (6-bit chain).
module tb_grid_io_multi_cfg;

  localparam int NP = 2;

  logic prog_clk;
  logic pReset;
  logic ccff_head;
  logic ccff_en;
  logic ccff_commit;
  logic ccff_readback;
  logic ccff_tail;
  logic cfg_valid;
  logic cfg_err;

  int n_checks;
  int n_errors;

  grid_io_multi_cfg_if #(.NUM_PADS(NP)) pads ();

  grid_io_multi_cfg #(.NUM_PADS(NP)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .ccff_head     (ccff_head),
    .ccff_en       (ccff_en),
    .ccff_commit   (ccff_commit),
`ifdef GRID_IO_READBACK_EN
    .ccff_readback (ccff_readback),
`endif
    .ccff_tail     (ccff_tail),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err),
    .pads          (pads)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    string      name;
    logic [1:0] outpad;
    logic [1:0] oe_fab;
    logic [1:0] pad_in;
    logic [1:0] exp_inpad;
    logic [1:0] exp_out;
    logic [1:0] exp_oe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    tick();
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic shift_word(input logic [5:0] w);
    for (int i = 5; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic commit();
    ccff_commit = 1'b1;
    tick();
    ccff_commit = 1'b0;
  endtask

  task automatic check_pads(input string name, input logic [1:0] inpad,
                            input logic [1:0] out, input logic [1:0] oe);
    check({name, "_inpad"}, 32'(pads.io_inpad), 32'(inpad));
    check({name, "_out"},   32'(pads.gfpga_pad_GPIO_PAD_out), 32'(out));
    check({name, "_oe"},    32'(pads.gfpga_pad_GPIO_PAD_oe), 32'(oe));
  endtask

  initial begin
    logic [5:0] rb_bits;
    n_checks = 0;
    n_errors = 0;

    // pad1 bidir unregistered, pad0 input unregistered
    vecs[0] = '{"bidir_v0", 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    vecs[1] = '{"bidir_v1", 2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    vecs[2] = '{"bidir_v2", 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10};
    vecs[3] = '{"bidir_v3", 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    vecs[4] = '{"bidir_v4", 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};

    pReset        = 1'b1;
    ccff_head     = 1'b0;
    ccff_en       = 1'b0;
    ccff_commit   = 1'b0;
    ccff_readback = 1'b0;
    pads.io_outpad             = '0;
    pads.io_oe_fabric          = '0;
    pads.gfpga_pad_GPIO_PAD_in = '0;

    for (int c = 0; c < 2; c++) begin
      ccff_head   = 1'($urandom_range(0, 1));
      ccff_en     = 1'($urandom_range(0, 1));
      ccff_commit = 1'($urandom_range(0, 1));
      pads.io_outpad             = 2'($urandom_range(0, 3));
      pads.io_oe_fabric          = 2'($urandom_range(0, 3));
      pads.gfpga_pad_GPIO_PAD_in = 2'($urandom_range(0, 3));
      tick();
      check_pads("reset", 2'b00, 2'b00, 2'b00);
      check("reset_tail",  32'(ccff_tail), 32'd0);
      check("reset_valid", 32'(cfg_valid), 32'd0);
      check("reset_err",   32'(cfg_err),   32'd0);
    end
    pReset      = 1'b0;
    ccff_head   = 1'b0;
    ccff_en     = 1'b0;
    ccff_commit = 1'b0;
    pads.io_outpad             = '0;
    pads.io_oe_fabric          = '0;
    pads.gfpga_pad_GPIO_PAD_in = '0;
    tick();

    // pad1 = {1,01} registered input, pad0 = {1,10} registered output
    shift_word(6'b101110);
    check("pre_commit_valid", 32'(cfg_valid), 32'd0);
    commit();
    check("commit1_valid", 32'(cfg_valid), 32'd1);
    check("commit1_err",   32'(cfg_err),   32'd0);
    pads.gfpga_pad_GPIO_PAD_in = 2'b10;
    pads.io_outpad             = 2'b01;
    #1;
    check_pads("reg_before", 2'b00, 2'b00, 2'b01);
    tick();
    check_pads("reg_after", 2'b10, 2'b01, 2'b01);

    // Short count: rejected, live config untouched
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    commit();
    check("short_err",   32'(cfg_err),   32'd1);
    check("short_valid", 32'(cfg_valid), 32'd1);
    check_pads("short_hold", 2'b10, 2'b01, 2'b01);

    // pad1 = {0,11} bidir unregistered, pad0 = {0,01} input unregistered
    shift_word(6'b011001);
    commit();
    check("recommit_err",   32'(cfg_err),   32'd0);
    check("recommit_valid", 32'(cfg_valid), 32'd1);

    for (int v = 0; v < 5; v++) begin
      pads.io_outpad             = vecs[v].outpad;
      pads.io_oe_fabric          = vecs[v].oe_fab;
      pads.gfpga_pad_GPIO_PAD_in = vecs[v].pad_in;
      #1;
      check_pads(vecs[v].name, vecs[v].exp_inpad, vecs[v].exp_out, vecs[v].exp_oe);
    end
    pads.io_outpad             = '0;
    pads.io_oe_fabric          = '0;
    pads.gfpga_pad_GPIO_PAD_in = '0;

    // Commit with ccff_en in the same cycle: shift suppressed, count cleared
    shift_bit(1'b1);
    shift_bit(1'b1);
    check("pre_collide_tail", 32'(ccff_tail), 32'd1);
    ccff_head   = 1'b0;
    ccff_en     = 1'b1;
    ccff_commit = 1'b1;
    tick();
    ccff_en     = 1'b0;
    ccff_commit = 1'b0;
    check("collide_err",  32'(cfg_err),   32'd1);
    check("collide_tail", 32'(ccff_tail), 32'd1);
    shift_word(6'b110110);
    check("tail_after6", 32'(ccff_tail), 32'd1);
    commit();
    check("collide_clear_err", 32'(cfg_err), 32'd0);
    #1;
    check_pads("out2_before", 2'b00, 2'b00, 2'b11);
    pads.io_outpad = 2'b10;
    tick();
    check_pads("out2_after", 2'b00, 2'b10, 2'b11);

    // Overshift: 7 bits, first bit reaches tail after 6 shifts
    shift_bit(1'b1);
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    check("over_tail6", 32'(ccff_tail), 32'd1);
    shift_bit(1'b0);
    check("over_tail7", 32'(ccff_tail), 32'd0);
    commit();
    check("over_err",   32'(cfg_err),   32'd1);
    check("over_valid", 32'(cfg_valid), 32'd1);
    check_pads("over_hold", 2'b00, 2'b10, 2'b11);

`ifdef GRID_IO_READBACK_EN
    rb_bits = 6'b110110;
    ccff_readback = 1'b1;
    tick();
    ccff_readback = 1'b0;
    check("rb_tail5", 32'(ccff_tail), 32'(rb_bits[5]));
    commit();
    check("rb_commit_err", 32'(cfg_err), 32'd0);
    for (int i = 4; i >= 0; i--) begin
      shift_bit(1'b0);
      check("rb_tail", 32'(ccff_tail), 32'(rb_bits[i]));
    end
    check_pads("rb_hold", 2'b00, 2'b10, 2'b11);
`else
    rb_bits = '0;
    check("rb_absent_tail", 32'(ccff_tail), 32'(rb_bits[0]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
